// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_e;

  localparam int unsigned GAP_CNT_W = 8;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating priority search: first valid requester strictly after ptr, wrapping.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found_c,
  output logic [IDX_W-1:0]   idx_c
);

  logic [IDX_W:0] cand;

  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    cand    = '0;
    for (int unsigned s = 1; s <= NUM_REQ; s++) begin
      cand = (IDX_W+1)'(ptr) + (IDX_W+1)'(s);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found_c && valid[cand[IDX_W-1:0]]) begin
        found_c = 1'b1;
        idx_c   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_TX_ARB_WATCHDOG_EN to add the Busy-rise watchdog and Err_Timeout.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  localparam int unsigned IDX_W = idx_width(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  output logic [NUM_REQ-1:0]            Req_Ready,
  input  logic                          Busy,
  output logic                          Data_Valid,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic [IDX_W-1:0]              Grant_Id,
  output logic                          Arb_Busy,
  output logic                          Err_Timeout
);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]     ready_q, ready_d;
  logic                   dv_q, dv_d;
  logic [DATA_WIDTH-1:0]  pdata_q, pdata_d;
  logic [IDX_W-1:0]       gid_q, gid_d;
  logic                   abusy_q;
  logic                   pick_found_c;
  logic [IDX_W-1:0]       pick_idx_c;
  logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = idx_width(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid   (Req_Valid),
    .ptr     (ptr_q),
    .found_c (pick_found_c),
    .idx_c   (pick_idx_c)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++)
      req_bytes[i] = Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state and next-output decode; launch outputs are single-cycle pulses.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    ready_d   = '0;
    dv_d      = 1'b0;
    pdata_d   = pdata_q;
    gid_d     = gid_q;
`ifdef UART_TX_ARB_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found_c && !Busy) begin
          ready_d[pick_idx_c] = 1'b1;
          dv_d    = 1'b1;
          pdata_d = req_bytes[pick_idx_c];
          gid_d   = pick_idx_c;
          ptr_d   = pick_idx_c;
          state_d = ST_WAIT_BUSY;
`ifdef UART_TX_ARB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
        end
      end
      ST_WAIT_BUSY: begin
        if (Busy) begin
          state_d = ST_WAIT_DONE;
        end
`ifdef UART_TX_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (!Busy) begin
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Pointer starts at the top so requester 0 wins the first arbitration.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      gap_cnt_q <= '0;
      ready_q   <= '0;
      dv_q      <= 1'b0;
      pdata_q   <= '0;
      gid_q     <= '0;
      abusy_q   <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
      ready_q   <= ready_d;
      dv_q      <= dv_d;
      pdata_q   <= pdata_d;
      gid_q     <= gid_d;
      abusy_q   <= (state_d != ST_IDLE);
    end
  end

`ifdef UART_TX_ARB_WATCHDOG_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end
  assign Err_Timeout = err_q;
`else
  assign Err_Timeout = 1'b0;
`endif

  assign Req_Ready  = ready_q;
  assign Data_Valid = dv_q;
  assign P_DATA     = pdata_q;
  assign Grant_Id   = gid_q;
  assign Arb_Busy   = abusy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a rule-level reference model predicts
// each launch (and watchdog expiry) and a monitor checks what the DUT presents.
module tb_uart_tx_arbiter;

  localparam int unsigned N      = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned GAP    = 3;
  localparam int unsigned TO     = 15;
  localparam int unsigned IW     = uart_tx_arb_pkg::idx_width(N);
  localparam int          TX_LEN = 11;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  Req_Valid;
  logic [N*DW-1:0] Req_Data;
  logic [N-1:0]  Req_Ready;
  logic          Busy = 1'b0;
  logic          Data_Valid;
  logic [DW-1:0] P_DATA;
  logic [IW-1:0] Grant_Id;
  logic          Arb_Busy;
  logic          Err_Timeout;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .Req_Valid(Req_Valid), .Req_Data(Req_Data),
    .Req_Ready(Req_Ready), .Busy(Busy), .Data_Valid(Data_Valid),
    .P_DATA(P_DATA), .Grant_Id(Grant_Id), .Arb_Busy(Arb_Busy),
    .Err_Timeout(Err_Timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    int          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t dv_q[$];
  int   err_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic foreign = 1'b0;
  logic dead_tx = 1'b0;
  int   tx_lo = 1;
  int   tx_hi = 0;
  logic [N-1:0] rdy_last = '0;

  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Transmitter model: Busy high 2 cycles after a launch, for TX_LEN cycles.
  always @(negedge CLK) begin
    rdy_last = Req_Ready;
    if (!RST) begin
      tx_lo = 1;
      tx_hi = 0;
    end else if (Data_Valid && !dead_tx) begin
      tx_lo = cyc + 2;
      tx_hi = cyc + 1 + TX_LEN;
    end
  end

  always @(posedge CLK) begin
    #2;
    Busy = foreign || (cyc >= tx_lo && cyc <= tx_hi);
  end

  // Reference model: decides grants from the sampled inputs of each cycle.
  int ptr_m   = N - 1;
  bit fly     = 1'b0;
  bit seen    = 1'b0;
  int dv_c    = 0;
  int free_at = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      ptr_m = N - 1; fly = 1'b0; seen = 1'b0; free_at = 0;
      dv_q.delete(); err_q.delete();
    end else if (fly) begin
      if (!seen) begin
        if (Busy) seen = 1'b1;
`ifdef UART_TX_ARB_WATCHDOG_EN
        else if (cyc == dv_c + TO - 1) begin
          err_q.push_back(cyc + 1);
          fly = 1'b0;
          free_at = cyc + 1;
        end
`endif
      end else if (!Busy) begin
        fly = 1'b0;
        free_at = cyc + GAP + 1;
      end
    end else if (cyc >= free_at && Req_Valid != '0 && !Busy) begin
      bit   got;
      exp_t e;
      got = 1'b0;
      for (int s = 1; s <= N; s++) begin
        int g;
        g = (ptr_m + s) % N;
        if (!got && Req_Valid[g]) begin
          got = 1'b1;
          e.cyc = cyc + 1; e.id = g; e.data = Req_Data[g*DW +: DW];
          dv_q.push_back(e);
          ptr_m = g; fly = 1'b1; seen = 1'b0; dv_c = cyc + 1;
        end
      end
    end
  end

  // Monitor: pops the expectation whenever the DUT launches or flags a timeout.
  logic [DW-1:0] held_d = '0;

  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      if (Data_Valid) begin
        if (dv_q.size() == 0) begin
          check("unexpected_launch", longint'(Grant_Id), -1);
        end else begin
          e = dv_q.pop_front();
          check("launch_cycle", cyc, e.cyc);
          check("grant_id", Grant_Id, e.id);
          check("p_data", P_DATA, e.data);
          check("req_ready", Req_Ready, longint'(1) << e.id);
          check("busy_at_launch", Busy, 0);
          check("arb_busy_at_launch", Arb_Busy, 1);
          held_d = e.data;
        end
      end else begin
        check("ready_without_launch", Req_Ready, 0);
        if (Arb_Busy) check("p_data_hold", P_DATA, held_d);
      end
      if (Err_Timeout) begin
        if (err_q.size() == 0) check("unexpected_timeout", 1, 0);
        else check("timeout_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    Req_Valid = Req_Valid & ~rdy_last;
  endtask

  task automatic raise(int i, logic [DW-1:0] d);
    Req_Valid[i] = 1'b1;
    Req_Data[i*DW +: DW] = d;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((Req_Valid != '0 || Arb_Busy || dv_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_budget", n < budget, 1);
  endtask

  initial begin
    int n;
    RST = 1'b1; Req_Valid = '0; Req_Data = '0;
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", Req_Ready, 0);
    check("rst_dv", Data_Valid, 0);
    check("rst_pdata", P_DATA, 0);
    check("rst_gid", Grant_Id, 0);
    check("rst_arb_busy", Arb_Busy, 0);
    check("rst_err", Err_Timeout, 0);
    step(); RST = 1'b1;
    repeat (3) step();

    // Single request from requester 2.
    raise(2, 8'hA5);
    step();
    check("single_dv", Data_Valid, 1);
    check("single_ready", Req_Ready, 4'b0100);
    check("single_pdata", P_DATA, 8'hA5);
    check("single_gid", Grant_Id, 2);
    drain(100);

    // All sources requesting continuously.
    for (int c = 0; c < 90; c++) begin
      step();
      for (int i = 0; i < N; i++)
        if (!Req_Valid[i]) raise(i, 8'($urandom));
    end
    drain(200);

    // Foreign Busy while idle blocks the grant.
    foreign = 1'b1;
    step();
    raise(0, 8'h3C);
    repeat (6) step();
    foreign = 1'b0;
    drain(60);

    // Reset while the transmitter is mid-frame.
    raise(1, 8'h11); raise(2, 8'h22);
    n = 0;
    do begin step(); #2; n++; end while (!Busy && n < 30);
    check("busy_rise_seen", Busy, 1);
    step(); step();
    Req_Valid = 4'b1001;
    Req_Data[0 +: DW] = 8'h5A;
    Req_Data[3*DW +: DW] = 8'hC3;
    #2 RST = 1'b0;
    #1;
    check("midrst_ready", Req_Ready, 0);
    check("midrst_dv", Data_Valid, 0);
    check("midrst_pdata", P_DATA, 0);
    check("midrst_gid", Grant_Id, 0);
    check("midrst_arb_busy", Arb_Busy, 0);
    check("midrst_err", Err_Timeout, 0);
    step(); step();
    RST = 1'b1;
    step();
    check("post_rst_dv", Data_Valid, 1);
    check("post_rst_gid", Grant_Id, 0);
    drain(100);

`ifdef UART_TX_ARB_WATCHDOG_EN
    // Transmitter never answers: every grant times out and rotates.
    dead_tx = 1'b1;
    for (int c = 0; c < 70; c++) begin
      step();
      if (!Req_Valid[1]) raise(1, 8'($urandom));
      if (!Req_Valid[2]) raise(2, 8'($urandom));
    end
    dead_tx = 1'b0;
    drain(200);
`endif

    // Random traffic, including requests withdrawn before being served.
    for (int c = 0; c < 700; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (Req_Valid[i]) begin
          if ($urandom_range(0, 31) == 0) Req_Valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          raise(i, 8'($urandom));
        end
      end
    end
    drain(300);
    repeat (4) step();

    check("launches_outstanding", dv_q.size(), 0);
    check("timeouts_outstanding", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
